// File: rtl/memset_stream_ctrl_if.sv
// Valid/ready beat stream carrying the memset fill pattern
// from the controller to the streamer write port.
interface memset_stream_ctrl_if #(
    parameter int unsigned DataWidth = 512
);
    logic                   valid;
    logic                   ready;
    logic [DataWidth-1:0]   bits;
    logic [DataWidth/8-1:0] strb;
    logic                   last;

    modport master (
        output valid,
        output bits,
        output strb,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  bits,
        input  strb,
        input  last,
        output ready
    );
endinterface

// File: rtl/memset_stream_ctrl.sv
// Memset sequencing controller: turns one start command into a
// bounded stream of fill beats with a partial tail strobe.
module memset_stream_ctrl #(
    parameter int unsigned DataWidth = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          ext_csr_i_0,
    input  logic [31:0]          ext_csr_i_1,
    input  logic                 ext_start_i,
    output logic                 ext_busy_o,
    output logic                 ext_done_o,
    output logic [31:0]          ext_stall_cnt_o,
    memset_stream_ctrl_if.master ext_data_o
);
    localparam int unsigned BytesPerBeat = DataWidth / 8;
    localparam int unsigned BeatShift    = $clog2(BytesPerBeat);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [BytesPerBeat-1:0] tail_q, tail_d;
    logic [31:0]             rem_q, rem_d;
    logic [31:0]             stall_q, stall_d;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic [DataWidth-1:0]    bits_q, bits_d;
    logic [BytesPerBeat-1:0] strb_q, strb_d;

    logic [31:0]             len_mod;
    logic [31:0]             num_beats;
    logic [BytesPerBeat-1:0] new_tail;
    logic [7:0]              fill;
    logic [23:0]             unused_csr;

    assign fill       = ext_csr_i_0[7:0];
    assign unused_csr = ext_csr_i_0[31:8];

    // Byte remainder of the length picks the tail strobe and a rounding beat.
    assign len_mod   = ext_csr_i_1 & 32'(BytesPerBeat - 1);
    assign num_beats = (ext_csr_i_1 >> BeatShift)
                     + {31'd0, len_mod != 32'd0};
    assign new_tail  = (len_mod == 32'd0) ? '1
                     : ~({BytesPerBeat{1'b1}} << len_mod);

    always_comb begin
        state_d = state_q;
        tail_d  = tail_q;
        rem_d   = rem_q;
        stall_d = stall_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        bits_d  = bits_q;
        strb_d  = strb_q;
        unique case (state_q)
            IDLE: begin
                if (ext_start_i) begin
                    stall_d = '0;
                    if (ext_csr_i_1 == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        tail_d  = new_tail;
                        rem_d   = num_beats;
                        valid_d = 1'b1;
                        bits_d  = {BytesPerBeat{fill}};
                        last_d  = (num_beats == 32'd1);
                        strb_d  = (num_beats == 32'd1) ? new_tail : '1;
                    end
                end
            end
            RUN: begin
                if (ext_data_o.ready) begin
                    if (rem_q == 32'd1) begin
                        state_d = IDLE;
                        rem_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                        bits_d  = '0;
                        strb_d  = '0;
                    end else begin
                        rem_d  = rem_q - 32'd1;
                        last_d = (rem_q == 32'd2);
                        strb_d = (rem_q == 32'd2) ? tail_q : '1;
                    end
                end else if (stall_q != 32'hFFFF_FFFF) begin
                    stall_d = stall_q + 32'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tail_q  <= '0;
            rem_q   <= '0;
            stall_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            bits_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            tail_q  <= tail_d;
            rem_q   <= rem_d;
            stall_q <= stall_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            bits_q  <= bits_d;
            strb_q  <= strb_d;
        end
    end

    assign ext_busy_o       = (state_q == RUN);
    assign ext_done_o       = done_q;
    assign ext_stall_cnt_o  = stall_q;
    assign ext_data_o.valid = valid_q;
    assign ext_data_o.bits  = bits_q;
    assign ext_data_o.strb  = strb_q;
    assign ext_data_o.last  = last_q;
endmodule

// File: tb/tb_memset_stream_ctrl.sv
// Directed scoreboard bench for memset_stream_ctrl.
module tb_memset_stream_ctrl;
    localparam int DW  = 512;
    localparam int BPB = DW / 8;

    typedef struct packed {
        logic [DW-1:0]  bits;
        logic [BPB-1:0] strb;
        logic           last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] csr0;
    logic [31:0] csr1;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] stall;

    memset_stream_ctrl_if #(.DataWidth(DW)) ext_data_o ();

    memset_stream_ctrl #(.DataWidth(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ext_csr_i_0     (csr0),
        .ext_csr_i_1     (csr1),
        .ext_start_i     (start),
        .ext_busy_o      (busy),
        .ext_done_o      (done),
        .ext_stall_cnt_o (stall),
        .ext_data_o      (ext_data_o)
    );

    always #5 clk = ~clk;

    beat_t          sb[$];
    int             total = 0;
    int             bad = 0;
    int             done_cnt = 0;
    int             beat_cnt = 0;
    logic           busy_seen = 1'b0;
    logic [BPB-1:0] last_strb = '0;
    logic           prev_stall = 1'b0;
    beat_t          prev_beat;

    task automatic chk(input string tag, input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference beats for one command, pushed when the command is driven.
    task automatic push_model(input logic [7:0] f, input logic [31:0] l);
        beat_t b;
        int    n;
        int    r;
        r = int'(l % 32'(BPB));
        n = int'(l / 32'(BPB)) + ((r != 0) ? 1 : 0);
        for (int i = 0; i < n; i++) begin
            b.bits = {BPB{f}};
            b.last = (i == n - 1);
            for (int j = 0; j < BPB; j++)
                b.strb[j] = !(b.last && r != 0) || (j < r);
            sb.push_back(b);
        end
    endtask

    task automatic issue(input logic [7:0] f, input logic [31:0] l);
        push_model(f, l);
        csr0  = {$urandom_range(255, 1) == 0 ? 24'h0 : 24'hBEEF00, f};
        csr1  = l;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, DW'(ext_data_o.valid), DW'(0));
        chk({tag, "_bits"}, ext_data_o.bits, DW'(0));
        chk({tag, "_strb"}, DW'(ext_data_o.strb), DW'(0));
        chk({tag, "_last"}, DW'(ext_data_o.last), DW'(0));
        chk({tag, "_busy"}, DW'(busy), DW'(0));
        chk({tag, "_done"}, DW'(done), DW'(0));
        chk({tag, "_stall"}, DW'(stall), DW'(0));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            beat_t e;
            if (prev_stall) begin
                chk("hold_valid", DW'(ext_data_o.valid), DW'(1));
                chk("hold_bits", ext_data_o.bits, prev_beat.bits);
                chk("hold_strb", DW'(ext_data_o.strb), DW'(prev_beat.strb));
                chk("hold_last", DW'(ext_data_o.last), DW'(prev_beat.last));
            end
            if (busy)
                busy_seen = 1'b1;
            if (done)
                done_cnt++;
            if (ext_data_o.valid)
                chk("busy_with_valid", DW'(busy), DW'(1));
            if (ext_data_o.valid && ext_data_o.ready) begin
                beat_cnt++;
                last_strb = ext_data_o.strb;
                chk("beat_expected", DW'(sb.size() != 0), DW'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("beat_bits", ext_data_o.bits, e.bits);
                    chk("beat_strb", DW'(ext_data_o.strb), DW'(e.strb));
                    chk("beat_last", DW'(ext_data_o.last), DW'(e.last));
                end
            end
            prev_stall = ext_data_o.valid && !ext_data_o.ready;
            prev_beat  = '{ext_data_o.bits, ext_data_o.strb, ext_data_o.last};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        int         dc;
        int         bc;
        logic [5:0] pat;

        rst_n            = 1'b0;
        csr0             = '0;
        csr1             = '0;
        start            = 1'b0;
        ext_data_o.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned fill: two full beats.
        ext_data_o.ready = 1'b1;
        dc = done_cnt;
        bc = beat_cnt;
        issue(8'hA5, 32'd128);
        wait_done(cyc);
        chk("t1_done_lat", DW'(cyc), DW'(3));
        chk("t1_stall", DW'(stall), DW'(0));
        chk("t1_beats", DW'(beat_cnt - bc), DW'(2));
        chk("t1_done_cnt", DW'(done_cnt - dc), DW'(1));
        chk("t1_sb_empty", DW'(sb.size()), DW'(0));

        // Partial tail beat of 36 bytes.
        issue(8'h5A, 32'd100);
        wait_done(cyc);
        chk("t2_done_lat", DW'(cyc), DW'(3));
        chk("t2_tail_strb", DW'(last_strb), DW'(64'h0000_000F_FFFF_FFFF));
        chk("t2_sb_empty", DW'(sb.size()), DW'(0));

        // Zero length, then a single byte.
        busy_seen = 1'b0;
        bc = beat_cnt;
        issue(8'h77, 32'd0);
        wait_done(cyc);
        chk("t3_zero_lat", DW'(cyc), DW'(1));
        chk("t3_zero_busy", DW'(busy_seen), DW'(0));
        chk("t3_zero_beats", DW'(beat_cnt - bc), DW'(0));
        issue(8'hC3, 32'd1);
        wait_done(cyc);
        chk("t3_one_lat", DW'(cyc), DW'(2));
        chk("t3_one_strb", DW'(last_strb), DW'(1));
        chk("t3_sb_empty", DW'(sb.size()), DW'(0));

        // Back-pressure: ready 1,0,0,1,0,1.
        ext_data_o.ready = 1'b0;
        dc = done_cnt;
        bc = beat_cnt;
        pat = 6'b101001;
        issue(8'h96, 32'd192);
        for (int k = 0; k < 6; k++) begin
            ext_data_o.ready = pat[k];
            @(posedge clk);
            #1;
        end
        ext_data_o.ready = 1'b1;
        wait_done(cyc);
        chk("t4_done_lat", DW'(cyc), DW'(1));
        chk("t4_stall", DW'(stall), DW'(3));
        chk("t4_beats", DW'(beat_cnt - bc), DW'(3));
        repeat (3) @(posedge clk);
        #1;
        chk("t4_stall_hold", DW'(stall), DW'(3));
        chk("t4_done_cnt", DW'(done_cnt - dc), DW'(1));
        chk("t4_sb_empty", DW'(sb.size()), DW'(0));

        // Restart and CSR change during RUN are ignored.
        dc = done_cnt;
        bc = beat_cnt;
        issue(8'h11, 32'd256);
        @(posedge clk);
        #1;
        csr0  = 32'h0000_0022;
        csr1  = 32'd64;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        csr0  = 32'h0000_0033;
        wait_done(cyc);
        chk("t5_done_lat", DW'(cyc), DW'(3));
        repeat (3) @(posedge clk);
        #1;
        chk("t5_beats", DW'(beat_cnt - bc), DW'(4));
        chk("t5_done_cnt", DW'(done_cnt - dc), DW'(1));
        chk("t5_sb_empty", DW'(sb.size()), DW'(0));

        // Asynchronous reset during beat 2 of 4.
        issue(8'h44, 32'd256);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_rst");
        sb.delete();
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done", DW'(done_cnt - dc), DW'(0));
        chk("t6_idle_valid", DW'(ext_data_o.valid), DW'(0));
        bc = beat_cnt;
        issue(8'h3C, 32'd64);
        wait_done(cyc);
        chk("t6_done_lat", DW'(cyc), DW'(2));
        chk("t6_beats", DW'(beat_cnt - bc), DW'(1));
        chk("t6_strb", DW'(last_strb), DW'({BPB{1'b1}}));
        chk("t6_sb_empty", DW'(sb.size()), DW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
